// File: rtl/eth_tx_fifo.sv
// Store-and-forward transmit FIFO: 512-bit AXI-Stream frames are released to the MAC
// only once their last beat is stored; frames longer than the buffer are dropped whole.
module eth_tx_fifo #(
    parameter int DEPTH = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         si_tvalid,
    output logic         si_tready,
    input  logic [511:0] si_tdata,
    input  logic [63:0]  si_tkeep,
    input  logic         si_tlast,
    output logic         tx_tvalid,
    input  logic         tx_tready,
    output logic [511:0] tx_tdata,
    output logic [63:0]  tx_tkeep,
    output logic         tx_tlast,
    output logic         tx_tuser,
    output logic [31:0]  dbg_total_packets,
    output logic [31:0]  dbg_dropped_packets
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0]  ptr_t;
    typedef logic [576:0]   beat_t;   // {tlast, tkeep, tdata}
    typedef enum logic { ST_ACCEPT, ST_DROP } wr_state_e;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    wr_state_e   state_q, state_d;
    ptr_t        wr_ptr_q, wr_ptr_d;
    ptr_t        commit_ptr_q, commit_ptr_d;
    ptr_t        rd_ptr_q, rd_ptr_d;
    logic [31:0] total_q, total_d;
    logic [31:0] dropped_q, dropped_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  ob_cnt_q, ob_cnt_d;
    beat_t       ob_q [2];
    beat_t       ob_d [2];

    beat_t       mem [DEPTH];
    beat_t       ram_rdata_q;
    logic        ram_we;
    logic        rd_issue;
    logic        tx_pop;
    logic [1:0]  ob_after_pop;

    ptr_t occupancy;
    ptr_t partial;
    ptr_t committed;
    logic oversize;

    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign partial   = wr_ptr_q - commit_ptr_q;
    assign committed = commit_ptr_q - rd_ptr_q;
    // A partial frame that already fills the whole buffer can never be committed.
    assign oversize  = (partial == DEPTH_P);

    // NOTE: every output of a combinational block gets a default first, so no path
    // through the case/if tree can leave a value held and infer a latch.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        total_d      = total_q;
        dropped_d    = dropped_q;
        ram_we       = 1'b0;
        si_tready    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_ACCEPT: begin
                    si_tready = (occupancy != DEPTH_P) || oversize;
                    if (si_tvalid && si_tready) begin
                        if (oversize) begin
                            wr_ptr_d  = commit_ptr_q;
                            dropped_d = dropped_q + 32'd1;
                            if (!si_tlast) begin
                                state_d = ST_DROP;
                            end
                        end else begin
                            ram_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + ptr_t'(1);
                            if (si_tlast) begin
                                commit_ptr_d = wr_ptr_q + ptr_t'(1);
                                total_d      = total_q + 32'd1;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    si_tready = 1'b1;
                    if (si_tvalid && si_tlast) begin
                        state_d = ST_ACCEPT;
                    end
                end
            endcase
        end
    end

    assign tx_pop       = tx_tvalid && tx_tready;
    assign ob_after_pop = ob_cnt_q - {1'b0, tx_pop};
    // Counting the slot freed by this cycle's pop keeps the read side at one beat per cycle.
    assign rd_issue     = !rst && (committed != '0) && ((ob_after_pop + {1'b0, inflight_q}) < 2'd2);

    always_comb begin
        rd_ptr_d   = rd_ptr_q + ptr_t'(rd_issue);
        inflight_d = rd_issue;
        ob_cnt_d   = ob_after_pop + {1'b0, inflight_q};
        ob_d[0]    = ob_q[0];
        ob_d[1]    = ob_q[1];
        if (tx_pop) begin
            ob_d[0] = ob_q[1];
        end
        if (inflight_q) begin
            if (ob_after_pop == 2'd0) begin
                ob_d[0] = ram_rdata_q;
            end else begin
                ob_d[1] = ram_rdata_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACCEPT;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            total_q      <= '0;
            dropped_q    <= '0;
            inflight_q   <= 1'b0;
            ob_cnt_q     <= '0;
            ob_q[0]      <= '0;
            ob_q[1]      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            total_q      <= total_d;
            dropped_q    <= dropped_d;
            inflight_q   <= inflight_d;
            ob_cnt_q     <= ob_cnt_d;
            ob_q[0]      <= ob_d[0];
            ob_q[1]      <= ob_d[1];
        end
    end

    // NOTE: the storage array and its read register are deliberately not reset; the
    // pointers and in-flight flag guarantee stale contents are never forwarded.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[wr_ptr_q[AW-1:0]] <= {si_tlast, si_tkeep, si_tdata};
        end
        if (rd_issue) begin
            ram_rdata_q <= mem[rd_ptr_q[AW-1:0]];
        end
    end

    assign tx_tvalid           = (ob_cnt_q != 2'd0);
    assign tx_tlast            = ob_q[0][576];
    assign tx_tkeep            = ob_q[0][575:512];
    assign tx_tdata            = ob_q[0][511:0];
    assign tx_tuser            = 1'b0;
    assign dbg_total_packets   = total_q;
    assign dbg_dropped_packets = dropped_q;

endmodule

// File: tb/tb_eth_tx_fifo.sv
// Directed bench for eth_tx_fifo at DEPTH=16: latency, back-to-back frames under random
// back-pressure, full stall, oversize drop and reset mid-frame, with a beat scoreboard.
module tb_eth_tx_fifo;

    localparam int DEPTH = 16;

    logic         clk;
    logic         rst;
    logic         si_tvalid;
    logic         si_tready;
    logic [511:0] si_tdata;
    logic [63:0]  si_tkeep;
    logic         si_tlast;
    logic         tx_tvalid;
    logic         tx_tready;
    logic [511:0] tx_tdata;
    logic [63:0]  tx_tkeep;
    logic         tx_tlast;
    logic         tx_tuser;
    logic [31:0]  dbg_total_packets;
    logic [31:0]  dbg_dropped_packets;

    eth_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .si_tvalid           (si_tvalid),
        .si_tready           (si_tready),
        .si_tdata            (si_tdata),
        .si_tkeep            (si_tkeep),
        .si_tlast            (si_tlast),
        .tx_tvalid           (tx_tvalid),
        .tx_tready           (tx_tready),
        .tx_tdata            (tx_tdata),
        .tx_tkeep            (tx_tkeep),
        .tx_tlast            (tx_tlast),
        .tx_tuser            (tx_tuser),
        .dbg_total_packets   (dbg_total_packets),
        .dbg_dropped_packets (dbg_dropped_packets)
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [576:0] exp_q [$];
    logic         in_frame = 1'b0;
    logic         rand_ready = 1'b0;
    logic [31:0]  seq = 32'h1000_0000;
    int           acc_cnt = 0;
    int           last_stalls = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [576:0] got, input logic [576:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 tx_tready = 1'($urandom_range(0, 1));
        end
    end

    // Scoreboard: every transferred beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            in_frame = 1'b0;
        end else begin
            if (in_frame) check("tx_gap", tx_tvalid, 1);
            if (tx_tvalid && tx_tready) begin
                if (exp_q.size() == 0) check("tx_expected", 577'(exp_q.size() != 0), 1);
                else check("tx_beat", {tx_tlast, tx_tkeep, tx_tdata}, exp_q.pop_front());
                in_frame = !tx_tlast;
            end
        end
    end

    // Called just after a posedge; returns just after the edge that accepted tlast.
    task automatic send_frame(input int len, input logic [63:0] last_keep);
        logic [576:0] beats [$];
        int stalls = 0;
        int n;
        for (int b = 0; b < len; b++) begin
            si_tdata  = {16{seq}};
            seq       = seq + 32'd1;
            si_tkeep  = (b == len - 1) ? last_keep : {64{1'b1}};
            si_tlast  = (b == len - 1);
            si_tvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!si_tready && n < 1000) begin
                stalls++;
                n++;
                @(negedge clk);
            end
            if (!si_tready) begin
                check("si_timeout", si_tready, 1);
                si_tvalid = 1'b0;
                return;
            end
            beats.push_back({si_tlast, si_tkeep, si_tdata});
            acc_cnt++;
            @(posedge clk);
            #1;
        end
        si_tvalid = 1'b0;
        si_tlast  = 1'b0;
        if (len <= DEPTH) begin
            foreach (beats[i]) exp_q.push_back(beats[i]);
        end
        last_stalls = stalls;
    endtask

    task automatic check_latency();
        @(negedge clk); check("lat_e0", tx_tvalid, 0);
        @(negedge clk); check("lat_e1", tx_tvalid, 0);
        @(negedge clk); check("lat_e2", tx_tvalid, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || tx_tvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst = 1'b1;
        si_tvalid = 1'b0;
        si_tdata = '0;
        si_tkeep = '0;
        si_tlast = 1'b0;
        tx_tready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_si_tready", si_tready, 0);
        check("rst_tx_tvalid", tx_tvalid, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("idle_si_tready", si_tready, 1);
        check("idle_tx_tvalid", tx_tvalid, 0);
        check("idle_tx_word", {tx_tlast, tx_tkeep, tx_tdata}, 0);
        check("idle_tx_tuser", tx_tuser, 0);
        check("idle_total", dbg_total_packets, 0);
        check("idle_dropped", dbg_dropped_packets, 0);
        @(posedge clk); #1;

        // Single 3-beat frame, latency and last-beat keep
        tx_tready = 1'b1;
        send_frame(3, 64'h0000_0000_FFFF_FFFF);
        check_latency();
        @(negedge clk);
        check("t1_b1_valid", tx_tvalid, 1);
        check("t1_b1_last", tx_tlast, 0);
        @(negedge clk);
        check("t1_b2_valid", tx_tvalid, 1);
        check("t1_b2_last", tx_tlast, 1);
        check("t1_b2_keep", tx_tkeep, 64'h0000_0000_FFFF_FFFF);
        check("t1_total", dbg_total_packets, 1);
        wait_drain();
        @(posedge clk); #1;

        // 64 back-to-back frames of 1..16 beats with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            logic [63:0] k;
            k = {64{1'b1}} >> i;
            send_frame((i % 16) + 1, (i == 5) ? 64'h0 : k);
        end
        wait_drain();
        rand_ready = 1'b0;
        check("t2_total", dbg_total_packets, 65);
        check("t2_dropped", dbg_dropped_packets, 0);
        @(posedge clk); #1 tx_tready = 1'b0;

        // Full buffer: two 8-beat frames, then a third stalls once 16 beats are resident
        base = acc_cnt;
        send_frame(8, {64{1'b1}});
        send_frame(8, {64{1'b1}});
        fork
            send_frame(8, 64'h00FF);
            begin
                int n = 0;
                while (acc_cnt != base + 18 && n < 500) begin
                    @(posedge clk);
                    n++;
                end
                check("t3_reach", acc_cnt - base, 18);
                repeat (4) begin
                    @(negedge clk);
                    check("t3_full_stall", si_tready, 0);
                end
                check("t3_hold", acc_cnt - base, 18);
                @(posedge clk); #1 tx_tready = 1'b1;
            end
        join
        wait_drain();
        check("t3_total", dbg_total_packets, 68);
        @(posedge clk); #1;

        // Oversize frame dropped whole, neighbours intact, exact-DEPTH frame passes
        send_frame(20, {64{1'b1}});
        check("t4_drop_nostall", last_stalls, 0);
        check("t4_dropped", dbg_dropped_packets, 1);
        check("t4_total_hold", dbg_total_packets, 68);
        send_frame(2, 64'h0000_0000_0000_000F);
        send_frame(16, 64'h0000_0000_0000_0003);
        wait_drain();
        check("t4_total", dbg_total_packets, 70);
        check("t4_dropped_end", dbg_dropped_packets, 1);
        @(posedge clk); #1;

        // Reset in the middle of transmitting a 10-beat frame
        send_frame(10, {64{1'b1}});
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t5_rst_si_tready", si_tready, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t5_tx_tvalid", tx_tvalid, 0);
        check("t5_total", dbg_total_packets, 0);
        check("t5_dropped", dbg_dropped_packets, 0);
        check("t5_si_tready", si_tready, 1);
        @(posedge clk); #1;
        send_frame(1, 64'h0000_0000_0000_0001);
        check_latency();
        wait_drain();
        check("t5_total_after", dbg_total_packets, 1);
        check("t5_dropped_after", dbg_dropped_packets, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
